sdram_arbiter: RTL and testbench

Two-master arbiter sharing the single Avalon-MM slave of the on-board SDRAM controller (16-bit, 4 banks × 4096 rows × 256 columns = 4M words). It sits between two local requesters (for example a DMA/streaming engine and a test engine) and the SDRAM controller's slave. Commands pass through a one-entry registered output stage. Outstanding reads are tracked in an in-order ID FIFO so returning read data reaches the correct master.

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_arb_id_fifo.sv | 47 ++++
 rtl/sdram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM arbiter.
package sdram_arb_pkg;
   localparam int DEF_ADDR_W = 22;
   localparam int DEF_DATA_W = 16;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_id_t;

   typedef struct packed {
      logic                    valid;
      logic                    we;
      logic [DEF_ADDR_W-1:0]   address;
      logic [DEF_DATA_W-1:0]   writedata;
      logic [DEF_DATA_W/8-1:0] byteenable;
   } sdr_cmd_t;
endpackage

// File: rtl/sdram_arb_id_fifo.sv
// In-order FIFO of master IDs for reads in flight; count doubles as the pending-read counter.
module sdram_arb_id_fifo
   import sdram_arb_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             push,
   input  master_id_t       push_id,
   input  logic             pop,
   output master_id_t       pop_id,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);
   master_id_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_id  = mem[rd_ptr];

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= M0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end
endmodule

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of the SDRAM controller Avalon-MM slave.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties); default is round-robin.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter  int ADDR_W      = DEF_ADDR_W,
   parameter  int DATA_W      = DEF_DATA_W,
   parameter  int MAX_PENDING = 8,
   localparam int BE_W        = DATA_W / 8,
   localparam int CNT_W       = $clog2(MAX_PENDING) + 1
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic [BE_W-1:0]   m0_byteenable,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [BE_W-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] sdr_address,
   output logic              sdr_read,
   output logic              sdr_write,
   output logic [DATA_W-1:0] sdr_writedata,
   output logic [BE_W-1:0]   sdr_byteenable,
   input  logic              sdr_waitrequest,
   input  logic [DATA_W-1:0] sdr_readdata,
   input  logic              sdr_readdatavalid,
   output logic              proto_err
);
   sdr_cmd_t          out_q;
   sdr_cmd_t          cmd_in;
   master_id_t        win;
   master_id_t        pop_id;
   logic              fifo_empty;
   logic              fifo_full;
   logic [CNT_W-1:0]  pending;
   logic              slot_free;
   logic              read_ok;
   logic              elig0;
   logic              elig1;
   logic              accept;
   logic              push;
   logic              pop_ok;
   logic              rdv0_q;
   logic              rdv1_q;
   logic              proto_err_q;
   logic [DATA_W-1:0] readdata_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
   master_id_t        last_q;
`endif

   // A master asserting both read and write is treated as a write.
   always_comb begin
      slot_free = !out_q.valid || !sdr_waitrequest;
      read_ok   = (pending < CNT_W'(MAX_PENDING)) && !fifo_full;
      elig0     = m0_write || (m0_read && read_ok);
      elig1     = m1_write || (m1_read && read_ok);
      win       = M0;
      if (elig0 && elig1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
         win = M0;
`else
         win = (last_q == M0) ? M1 : M0;
`endif
      end else if (elig1) begin
         win = M1;
      end
      accept         = (elig0 || elig1) && slot_free;
      m0_waitrequest = !(accept && (win == M0));
      m1_waitrequest = !(accept && (win == M1));
      cmd_in.valid   = 1'b1;
      if (win == M1) begin
         cmd_in.we         = m1_write;
         cmd_in.address    = m1_address;
         cmd_in.writedata  = m1_writedata;
         cmd_in.byteenable = m1_byteenable;
      end else begin
         cmd_in.we         = m0_write;
         cmd_in.address    = m0_address;
         cmd_in.writedata  = m0_writedata;
         cmd_in.byteenable = m0_byteenable;
      end
      push   = accept && !cmd_in.we;
      pop_ok = sdr_readdatavalid && !fifo_empty;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         out_q <= '0;
      end else if (slot_free) begin
         out_q.valid <= accept;
         if (accept) out_q <= cmd_in;
      end
   end

`ifndef SDRAM_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)  last_q <= M1;
      else if (accept)     last_q <= win;
   end
`endif

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rdv0_q      <= 1'b0;
         rdv1_q      <= 1'b0;
         readdata_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         rdv0_q <= pop_ok && (pop_id == M0);
         rdv1_q <= pop_ok && (pop_id == M1);
         if (pop_ok) readdata_q <= sdr_readdata;
         if ((m0_read && m0_write) || (m1_read && m1_write) ||
             (sdr_readdatavalid && fifo_empty))
            proto_err_q <= 1'b1;
      end
   end

   sdram_arb_id_fifo #(.DEPTH(MAX_PENDING)) u_id_fifo (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .push          (push),
      .push_id       (win),
      .pop           (sdr_readdatavalid),
      .pop_id        (pop_id),
      .empty         (fifo_empty),
      .full          (fifo_full),
      .count         (pending)
   );

   assign sdr_read         = out_q.valid && !out_q.we;
   assign sdr_write        = out_q.valid && out_q.we;
   assign sdr_address      = out_q.address;
   assign sdr_writedata    = out_q.writedata;
   assign sdr_byteenable   = out_q.byteenable;
   assign m0_readdata      = readdata_q;
   assign m1_readdata      = readdata_q;
   assign m0_readdatavalid = rdv0_q;
   assign m1_readdatavalid = rdv1_q;
   assign proto_err        = proto_err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized bench for sdram_arbiter against a transaction-level reference model.
module tb_sdram_arbiter;
   localparam int ADDR_W      = 22;
   localparam int DATA_W      = 16;
   localparam int BE_W        = 2;
   localparam int MAX_PENDING = 8;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b1;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] sdr_address;
   logic              sdr_read, sdr_write;
   logic [DATA_W-1:0] sdr_writedata;
   logic [BE_W-1:0]   sdr_byteenable;
   logic              sdr_waitrequest;
   logic [DATA_W-1:0] sdr_readdata;
   logic              sdr_readdatavalid;
   logic              proto_err;

   sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .sdr_address(sdr_address), .sdr_read(sdr_read), .sdr_write(sdr_write),
      .sdr_writedata(sdr_writedata), .sdr_byteenable(sdr_byteenable),
      .sdr_waitrequest(sdr_waitrequest), .sdr_readdata(sdr_readdata),
      .sdr_readdatavalid(sdr_readdatavalid), .proto_err(proto_err)
   );

   always #5 clk_clk = ~clk_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: command slot, queue of read owners, last winner, return path.
   bit                mv, mwe;
   logic [ADDR_W-1:0] maddr;
   logic [DATA_W-1:0] mwd;
   logic [BE_W-1:0]   mbe;
   int                mlast;
   int                ids[$];
   bit [1:0]          mrdv;
   logic [DATA_W-1:0] mrdata;
   bit                mperr;
   int                ctl_out;
   bit [1:0]          acc_m;

   bit [1:0]          obs_w, obs_rdv;
   logic [DATA_W-1:0] obs_rdata [2];
   logic [ADDR_W-1:0] obs_addr;
   bit                obs_perr;
   logic [DATA_W-1:0] il_vals [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      sdr_waitrequest = 0; sdr_readdatavalid = 0; sdr_readdata = '0;
   endtask

   task automatic model_reset();
      mv = 0; mwe = 0; maddr = '0; mwd = '0; mbe = '0; mlast = 1;
      ids.delete(); mrdv = '0; mrdata = '0; mperr = 0; ctl_out = 0;
   endtask

   task automatic do_reset();
      reset_reset_n = 1'b0;
      idle_inputs();
      @(posedge clk_clk); #1;
      check("rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
      check("rst_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
      check("rst_sdr_read", 32'(sdr_read), 32'd0);
      check("rst_sdr_write", 32'(sdr_write), 32'd0);
      check("rst_sdr_address", 32'(sdr_address), 32'd0);
      check("rst_sdr_writedata", 32'(sdr_writedata), 32'd0);
      check("rst_sdr_byteenable", 32'(sdr_byteenable), 32'd0);
      check("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
      check("rst_readdata", 32'({m1_readdata, m0_readdata}), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);
      @(posedge clk_clk); #1;
      reset_reset_n = 1'b1;
      model_reset();
   endtask

   // One clock: compare DUT against model mid-cycle, then advance the model over the edge.
   task automatic cycle();
      bit sf, el0, el1, acc;
      int win, id;
      @(negedge clk_clk);
      sf  = !mv || !sdr_waitrequest;
      el0 = m0_write || (m0_read && ids.size() < MAX_PENDING);
      el1 = m1_write || (m1_read && ids.size() < MAX_PENDING);
      if (el0 && el1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
         win = 0;
`else
         win = (mlast == 0) ? 1 : 0;
`endif
      end else begin
         win = el0 ? 0 : 1;
      end
      acc      = (el0 || el1) && sf;
      acc_m[0] = acc && (win == 0);
      acc_m[1] = acc && (win == 1);
      obs_w    = {m1_waitrequest, m0_waitrequest};
      obs_rdv  = {m1_readdatavalid, m0_readdatavalid};
      obs_rdata[0] = m0_readdata;
      obs_rdata[1] = m1_readdata;
      obs_addr = sdr_address;
      obs_perr = proto_err;
      check("m0_waitrequest", 32'(m0_waitrequest), 32'(!acc_m[0]));
      check("m1_waitrequest", 32'(m1_waitrequest), 32'(!acc_m[1]));
      check("sdr_read", 32'(sdr_read), 32'(mv && !mwe));
      check("sdr_write", 32'(sdr_write), 32'(mv && mwe));
      check("sdr_address", 32'(sdr_address), 32'(maddr));
      check("sdr_writedata", 32'(sdr_writedata), 32'(mwd));
      check("sdr_byteenable", 32'(sdr_byteenable), 32'(mbe));
      check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(mrdv[0]));
      check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(mrdv[1]));
      check("m0_readdata", 32'(m0_readdata), 32'(mrdata));
      check("m1_readdata", 32'(m1_readdata), 32'(mrdata));
      check("proto_err", 32'(proto_err), 32'(mperr));
      if (mv && !mwe && !sdr_waitrequest) ctl_out++;
      if (sdr_readdatavalid && ctl_out > 0) ctl_out--;
      mrdv = '0;
      if (sdr_readdatavalid) begin
         if (ids.size() > 0) begin
            id       = ids.pop_front();
            mrdv[id] = 1'b1;
            mrdata   = sdr_readdata;
         end else begin
            mperr = 1;
         end
      end
      if ((m0_read && m0_write) || (m1_read && m1_write)) mperr = 1;
      if (sf) mv = acc;
      if (acc) begin
         mwe   = (win == 0) ? m0_write : m1_write;
         maddr = (win == 0) ? m0_address : m1_address;
         mwd   = (win == 0) ? m0_writedata : m1_writedata;
         mbe   = (win == 0) ? m0_byteenable : m1_byteenable;
         if (!mwe) ids.push_back(win);
         mlast = win;
      end
      @(posedge clk_clk); #1;
   endtask

   task automatic drain();
      bit done = 0;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; sdr_waitrequest = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         sdr_readdatavalid = (ctl_out > 0);
         sdr_readdata      = 16'($urandom);
         cycle();
         done = (ids.size() == 0) && !mv && (ctl_out == 0);
      end
      sdr_readdatavalid = 0;
      check("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit we;
      m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
      m0_byteenable = '0; m1_byteenable = '0;
      idle_inputs();
      model_reset();
      il_vals[0] = 16'h1111; il_vals[1] = 16'h2222; il_vals[2] = 16'h3333; il_vals[3] = 16'h4444;
      do_reset();

      // Single m0 read, accepted in the first cycle after reset, returned 3 cycles after issue.
      m0_read = 1; m0_address = 22'h000123; m0_byteenable = 2'b11;
      cycle();
      check("first_cycle_accept", 32'(obs_w[0]), 32'd0);
      m0_read = 0;
      cycle();
      cycle();
      cycle();
      sdr_readdatavalid = 1; sdr_readdata = 16'hBEEF;
      cycle();
      sdr_readdatavalid = 0;
      cycle();
      check("beef_m0_valid", 32'(obs_rdv[0]), 32'd1);
      check("beef_m1_quiet", 32'(obs_rdv[1]), 32'd0);
      check("beef_data", 32'(obs_rdata[0]), 32'h0000BEEF);
      drain();

      // Both masters writing continuously.
      do_reset();
      m0_write = 1; m0_address = 22'h000100; m0_writedata = 16'hA000; m0_byteenable = 2'b11;
      m1_write = 1; m1_address = 22'h000200; m1_writedata = 16'hB000; m1_byteenable = 2'b10;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (acc_m[0]) m0_writedata = m0_writedata + 16'd1;
         if (acc_m[1]) m1_writedata = m1_writedata + 16'd1;
      end
      drain();

      // m1 fills the read window; writes still pass; first return frees a slot.
      m1_read = 1; m1_address = 22'h000200; n = 0;
      for (int k = 0; k < 20 && n < MAX_PENDING; k++) begin
         cycle();
         if (acc_m[1]) begin n++; m1_address = m1_address + 22'd1; end
      end
      check("window_filled", 32'(n), 32'(MAX_PENDING));
      m0_write = 1; m0_address = 22'h0ABCDE; m0_writedata = 16'hC0DE;
      cycle();
      check("ninth_read_held", 32'(obs_w[1]), 32'd1);
      check("write_while_full", 32'(obs_w[0]), 32'd0);
      m0_write = 0;
      cycle();
      cycle();
      check("still_held", 32'(obs_w[1]), 32'd1);
      sdr_readdatavalid = 1; sdr_readdata = 16'h7777;
      cycle();
      check("held_during_return", 32'(obs_w[1]), 32'd1);
      sdr_readdatavalid = 0;
      cycle();
      check("released_after_return", 32'(obs_w[1]), 32'd0);
      m1_read = 0;
      drain();

      // Interleaved reads, returns routed by order.
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) begin m0_read = 1; m0_address = 22'(k); end
         else begin m1_read = 1; m1_address = 22'(k); end
         cycle();
         m0_read = 0; m1_read = 0;
      end
      cycle();
      for (int k = 0; k < 5; k++) begin
         sdr_readdatavalid = (k < 4);
         sdr_readdata      = (k < 4) ? il_vals[k] : 16'h0;
         cycle();
         if (k > 0) begin
            check("il_route", 32'(obs_rdv[(k-1)%2]), 32'd1);
            check("il_data", 32'(obs_rdata[(k-1)%2]), 32'(il_vals[k-1]));
         end
      end
      sdr_readdatavalid = 0;
      cycle();
      drain();

      // Controller stall with a write held in the output register.
      m0_write = 1; m0_address = 22'h3ABCD; m0_writedata = 16'h5A5A; m0_byteenable = 2'b01;
      cycle();
      sdr_waitrequest = 1;
      m0_address = 22'h000777; m1_read = 1; m1_address = 22'h000888;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("stall_m0_wait", 32'(obs_w[0]), 32'd1);
         check("stall_m1_wait", 32'(obs_w[1]), 32'd1);
         check("stall_addr", 32'(obs_addr), 32'h0003ABCD);
      end
      sdr_waitrequest = 0;
      cycle();
      drain();

      // Randomized traffic with controller stalls and returns.
      for (int c = 0; c < 1500; c++) begin
         if (!m0_read && !m0_write && $urandom_range(1, 0) == 1) begin
            we = 1'($urandom); m0_write = we; m0_read = !we;
            m0_address = 22'($urandom); m0_writedata = 16'($urandom); m0_byteenable = 2'($urandom);
         end
         if (!m1_read && !m1_write && $urandom_range(1, 0) == 1) begin
            we = 1'($urandom); m1_write = we; m1_read = !we;
            m1_address = 22'($urandom); m1_writedata = 16'($urandom); m1_byteenable = 2'($urandom);
         end
         sdr_waitrequest   = ($urandom_range(3, 0) == 0);
         sdr_readdatavalid = (ctl_out > 0) && ($urandom_range(2, 0) != 0);
         sdr_readdata      = 16'($urandom);
         cycle();
         if (acc_m[0]) begin m0_read = 0; m0_write = 0; end
         if (acc_m[1]) begin m1_read = 0; m1_write = 0; end
      end
      drain();

      // Stray read data sets a sticky error.
      sdr_readdatavalid = 1; sdr_readdata = 16'hDEAD;
      cycle();
      sdr_readdatavalid = 0;
      for (int k = 0; k < 3; k++) cycle();
      check("stray_err_sticky", 32'(obs_perr), 32'd1);
      check("stray_no_valid", 32'(obs_rdv), 32'd0);
      do_reset();

      // Read and write together from one master.
      m0_read = 1; m0_write = 1; m0_address = 22'h000055; m0_writedata = 16'h1234;
      cycle();
      m0_read = 0; m0_write = 0;
      cycle();
      cycle();
      check("rw_err_sticky", 32'(obs_perr), 32'd1);
      drain();
      do_reset();

      // Reset with reads in flight forgets them.
      m1_read = 1; m1_address = 22'h000900;
      cycle();
      cycle();
      m1_read = 0;
      cycle();
      do_reset();
      sdr_readdatavalid = 1; sdr_readdata = 16'hFACE;
      cycle();
      sdr_readdatavalid = 0;
      cycle();
      check("reset_forgets_err", 32'(obs_perr), 32'd1);
      check("reset_forgets_valid", 32'(obs_rdv), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
